// File: rtl/rotator_scheduler_if.sv
// Sample, rotator and result signals of rotator_scheduler bundled as one interface.
// slave is the scheduler's view, master is the surrounding environment's view.
interface rotator_scheduler_if;
  localparam int unsigned SAMPLE_W = 18;
  localparam int unsigned SEL_W    = 5;
  localparam int unsigned BR_W     = 4;
  localparam int unsigned CNT_W    = 8;

  logic                       symEn;
  logic signed [SAMPLE_W-1:0] i;
  logic signed [SAMPLE_W-1:0] q;
  logic [SEL_W-1:0]           baseSel;
  logic [SEL_W-1:0]           stepH0;
  logic [SEL_W-1:0]           stepH1;
  logic                       hReset;
  logic                       overrunClr;

  logic                       rotSymEn;
  logic signed [SAMPLE_W-1:0] rotI;
  logic signed [SAMPLE_W-1:0] rotQ;
  logic [SEL_W-1:0]           rotSel;
  logic signed [SAMPLE_W-1:0] rotIIn;
  logic signed [SAMPLE_W-1:0] rotQIn;

  logic                       outValid;
  logic [BR_W-1:0]            outBranch;
  logic signed [SAMPLE_W-1:0] iOut;
  logic signed [SAMPLE_W-1:0] qOut;
  logic                       symDone;
  logic                       hIdx;
  logic                       busy;
  logic                       overrun;
  logic [CNT_W-1:0]           overrunCount;

  modport slave (
    input  symEn, i, q, baseSel, stepH0, stepH1, hReset, overrunClr, rotIIn, rotQIn,
    output rotSymEn, rotI, rotQ, rotSel, outValid, outBranch, iOut, qOut,
           symDone, hIdx, busy, overrun, overrunCount
  );

  modport master (
    output symEn, i, q, baseSel, stepH0, stepH1, hReset, overrunClr, rotIIn, rotQIn,
    input  rotSymEn, rotI, rotQ, rotSel, outValid, outBranch, iOut, qOut,
           symDone, hIdx, busy, overrun, overrunCount
  );
endinterface

// File: rtl/rotator_scheduler.sv
// Issues NUM_BRANCH rotation requests per symbol to a shared phase rotator and re-tags its outputs.
// Define ROT_SCHED_OVFCNT_EN to build the saturating overrun event counter.
module rotator_scheduler #(
  parameter int unsigned NUM_BRANCH  = 8,
  parameter int unsigned ROT_LATENCY = 3
) (
  input logic               clk,
  input logic               reset,
  rotator_scheduler_if.slave bus
);
  localparam int unsigned D_W   = 18;
  localparam int unsigned SEL_W = 5;
  localparam int unsigned BR_W  = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TAG_W = BR_W + 2;
  localparam logic [BR_W-1:0] LAST_K = BR_W'(NUM_BRANCH - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state;
  logic                   busyReg;
  logic                   rotSymEnReg;
  logic                   hIdxReg;
  logic                   hPend;
  logic                   overrunReg;
  logic                   outValidReg;
  logic                   symDoneReg;
  logic signed [D_W-1:0]  rotIReg;
  logic signed [D_W-1:0]  rotQReg;
  logic signed [D_W-1:0]  iOutReg;
  logic signed [D_W-1:0]  qOutReg;
  logic [SEL_W-1:0]       rotSelReg;
  logic [SEL_W-1:0]       stepReg;
  logic [BR_W-1:0]        issueBranch;
  logic [BR_W-1:0]        outBranchReg;
  logic [TAG_W-1:0]       tagPipe [ROT_LATENCY];

  logic                   overrunEvt;
  logic                   nextH;
  logic [SEL_W-1:0]       nextStep;
  logic [TAG_W-1:0]       issueTag;
  logic [TAG_W-1:0]       exitTag;

  // A new symbol is always accepted; it only counts as an overrun if it cuts a sequence short.
  assign overrunEvt = bus.symEn && (state == ISSUE) && (issueBranch != LAST_K);
  assign nextH      = (hPend || bus.hReset) ? 1'b0 : ~hIdxReg;
  assign nextStep   = nextH ? bus.stepH1 : bus.stepH0;
  assign issueTag   = {busyReg, busyReg && (issueBranch == LAST_K), issueBranch};
  assign exitTag    = tagPipe[ROT_LATENCY-1];

  // Issue sequencer: the registered rotator request stream and its branch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busyReg     <= 1'b0;
      rotSymEnReg <= 1'b0;
      rotIReg     <= '0;
      rotQReg     <= '0;
      rotSelReg   <= '0;
      stepReg     <= '0;
      issueBranch <= '0;
      hIdxReg     <= 1'b0;
      hPend       <= 1'b1;
    end else if (bus.symEn) begin
      state       <= ISSUE;
      busyReg     <= 1'b1;
      rotSymEnReg <= 1'b1;
      rotIReg     <= bus.i;
      rotQReg     <= bus.q;
      rotSelReg   <= bus.baseSel;
      stepReg     <= nextStep;
      issueBranch <= '0;
      hIdxReg     <= nextH;
      hPend       <= 1'b0;
    end else begin
      rotSymEnReg <= 1'b0;
      if (bus.hReset) hPend <= 1'b1;
      if (state == ISSUE) begin
        if (issueBranch == LAST_K) begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end else begin
          issueBranch <= issueBranch + BR_W'(1);
          rotSelReg   <= rotSelReg + stepReg;
        end
      end
    end
  end

  // Tag delay line matched to the rotator latency, then the result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < int'(ROT_LATENCY); j++) tagPipe[j] <= '0;
      outValidReg  <= 1'b0;
      symDoneReg   <= 1'b0;
      outBranchReg <= '0;
      iOutReg      <= '0;
      qOutReg      <= '0;
    end else begin
      tagPipe[0] <= issueTag;
      for (int j = 1; j < int'(ROT_LATENCY); j++) tagPipe[j] <= tagPipe[j-1];
      outValidReg <= exitTag[TAG_W-1];
      symDoneReg  <= exitTag[TAG_W-1] && exitTag[TAG_W-2];
      if (exitTag[TAG_W-1]) begin
        outBranchReg <= exitTag[BR_W-1:0];
        iOutReg      <= bus.rotIIn;
        qOutReg      <= bus.rotQIn;
      end
    end
  end

  // Sticky overrun flag; a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrunReg <= 1'b0;
    end else if (overrunEvt) begin
      overrunReg <= 1'b1;
    end else if (bus.overrunClr) begin
      overrunReg <= 1'b0;
    end
  end

`ifdef ROT_SCHED_OVFCNT_EN
  logic [CNT_W-1:0] ovCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovCnt <= '0;
    end else if (bus.overrunClr) begin
      ovCnt <= overrunEvt ? CNT_W'(1) : '0;
    end else if (overrunEvt && (ovCnt != {CNT_W{1'b1}})) begin
      ovCnt <= ovCnt + CNT_W'(1);
    end
  end

  assign bus.overrunCount = ovCnt;
`else
  assign bus.overrunCount = '0;
`endif

  assign bus.busy      = busyReg;
  assign bus.rotSymEn  = rotSymEnReg;
  assign bus.rotI      = rotIReg;
  assign bus.rotQ      = rotQReg;
  assign bus.rotSel    = rotSelReg;
  assign bus.hIdx      = hIdxReg;
  assign bus.overrun   = overrunReg;
  assign bus.outValid  = outValidReg;
  assign bus.symDone   = symDoneReg;
  assign bus.outBranch = outBranchReg;
  assign bus.iOut      = iOutReg;
  assign bus.qOut      = qOutReg;
endmodule

// File: tb/tb_rotator_scheduler.sv
// Self-checking bench for rotator_scheduler: per-cycle comparison against a schedule-based
// model, plus directed sequences with hand-computed expectations.
module tb_rotator_scheduler;
  localparam int unsigned NB = 8;
  localparam int unsigned RL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  rotator_scheduler_if bus();

  rotator_scheduler #(.NUM_BRANCH(NB), .ROT_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: expected issue per cycle, keyed by absolute cycle number.
  logic [4:0]         mSel [int];
  int                 mBr  [int];
  bit                 mLast[int];
  logic signed [17:0] mI   [int];
  logic signed [17:0] mQ   [int];
  logic signed [17:0] logRI[int];
  logic signed [17:0] logRQ[int];
  bit hCur, hPend, ovFlag;
  int ovCnt;

  // Per-cycle drive values, consumed by tick().
  bit dSym, dHr, dClr, dRel;
  logic [4:0] dBase, dS0, dS1;
  logic signed [17:0] dI, dQ;

  int selLog[$];
  int brLog[$];
  int validCnt, doneCnt, firstValid, lastValid, lastDone;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic clearLogs();
    selLog.delete();
    brLog.delete();
    validCnt = 0;
    doneCnt = 0;
    firstValid = -1;
    lastValid = -1;
    lastDone = -1;
  endtask

  task automatic modelReset();
    mSel.delete(); mBr.delete(); mLast.delete(); mI.delete(); mQ.delete();
    hCur = 1'b0;
    hPend = 1'b1;
    ovFlag = 1'b0;
    ovCnt = 0;
  endtask

  task automatic compareAll();
    bit eBusy, eVal;
    int src;
    eBusy = mSel.exists(cyc);
    check("busy", bus.busy, eBusy);
    if (eBusy) begin
      check("rotSymEn", bus.rotSymEn, mBr[cyc] == 0);
      check("rotSel", bus.rotSel, mSel[cyc]);
      check("rotI", bus.rotI, mI[cyc]);
      check("rotQ", bus.rotQ, mQ[cyc]);
    end else begin
      check("rotSymEn", bus.rotSymEn, 0);
    end
    check("hIdx", bus.hIdx, hCur);
    check("overrun", bus.overrun, ovFlag);
`ifdef ROT_SCHED_OVFCNT_EN
    check("overrunCount", bus.overrunCount, ovCnt);
`else
    check("overrunCount", bus.overrunCount, 0);
`endif
    src = cyc - int'(RL) - 1;
    eVal = mSel.exists(src);
    check("outValid", bus.outValid, eVal);
    if (eVal) begin
      check("symDone", bus.symDone, mLast[src]);
      check("outBranch", bus.outBranch, mBr[src]);
      check("iOut", bus.iOut, logRI[cyc-1]);
      check("qOut", bus.qOut, logRQ[cyc-1]);
    end else begin
      check("symDone", bus.symDone, 0);
    end
    if (bus.busy) selLog.push_back(int'(bus.rotSel));
    if (bus.outValid) begin
      brLog.push_back(int'(bus.outBranch));
      validCnt++;
      if (firstValid < 0) firstValid = cyc;
      lastValid = cyc;
    end
    if (bus.symDone) begin
      doneCnt++;
      lastDone = cyc;
    end
  endtask

  // Schedule the whole symbol at acceptance; a later symbol simply overwrites the tail.
  task automatic modelStep();
    bit busyNow, ovEvt, h;
    logic [4:0] st;
    busyNow = mSel.exists(cyc);
    ovEvt = dSym && busyNow && !mLast[cyc];
    if (dSym) begin
      h = (hPend || dHr) ? 1'b0 : !hCur;
      st = h ? dS1 : dS0;
      for (int k = 0; k < int'(NB); k++) begin
        mSel[cyc+1+k]  = 5'((int'(dBase) + k * int'(st)) % 32);
        mBr[cyc+1+k]   = k;
        mLast[cyc+1+k] = (k == int'(NB) - 1);
        mI[cyc+1+k]    = dI;
        mQ[cyc+1+k]    = dQ;
      end
      hCur = h;
      hPend = 1'b0;
    end else if (dHr) begin
      hPend = 1'b1;
    end
    if (ovEvt) ovFlag = 1'b1;
    else if (dClr) ovFlag = 1'b0;
    if (dClr) ovCnt = ovEvt ? 1 : 0;
    else if (ovEvt && ovCnt < 255) ovCnt++;
  endtask

  task automatic tick();
    logic signed [17:0] ri, rq;
    @(negedge clk);
    compareAll();
    if (dRel) reset = 1'b0;
    ri = 18'($urandom);
    rq = 18'($urandom);
    bus.symEn = dSym; bus.i = dI; bus.q = dQ; bus.baseSel = dBase;
    bus.stepH0 = dS0; bus.stepH1 = dS1; bus.hReset = dHr; bus.overrunClr = dClr;
    bus.rotIIn = ri; bus.rotQIn = rq;
    logRI[cyc] = ri;
    logRQ[cyc] = rq;
    if (!reset) modelStep();
    cyc++;
    dSym = 0; dHr = 0; dClr = 0; dRel = 0;
  endtask

  task automatic assertReset();
    @(negedge clk);
    compareAll();
    reset = 1'b1;
    #1;
    check("rst_rotI", bus.rotI, 0);        check("rst_rotQ", bus.rotQ, 0);
    check("rst_rotSel", bus.rotSel, 0);    check("rst_iOut", bus.iOut, 0);
    check("rst_qOut", bus.qOut, 0);        check("rst_outBranch", bus.outBranch, 0);
    check("rst_outValid", bus.outValid, 0); check("rst_symDone", bus.symDone, 0);
    check("rst_rotSymEn", bus.rotSymEn, 0); check("rst_busy", bus.busy, 0);
    check("rst_hIdx", bus.hIdx, 0);        check("rst_overrun", bus.overrun, 0);
    check("rst_overrunCount", bus.overrunCount, 0);
    modelReset();
    logRI[cyc] = bus.rotIIn;
    logRQ[cyc] = bus.rotQIn;
    cyc++;
  endtask

  task automatic newSample();
    dI = 18'($urandom);
    dQ = 18'($urandom);
  endtask

  initial begin
    int expA[8];
    int expB[11];
    int pick;
    dSym = 0; dHr = 0; dClr = 0; dRel = 0;
    dBase = 0; dS0 = 0; dS1 = 0; dI = 0; dQ = 0;
    bus.symEn = 0; bus.i = 0; bus.q = 0; bus.baseSel = 0; bus.stepH0 = 0; bus.stepH1 = 0;
    bus.hReset = 0; bus.overrunClr = 0; bus.rotIIn = 0; bus.rotQIn = 0;
    modelReset();
    clearLogs();
    repeat (3) tick();
    dRel = 1; tick();
    repeat (5) tick();

    // Basic sequence: base 3, step 5 from reset (h=0).
    clearLogs();
    expA = '{3, 8, 13, 18, 23, 28, 1, 6};
    newSample(); dBase = 5'd3; dS0 = 5'd5; dS1 = 5'd9; dSym = 1;
    pick = cyc; tick();
    repeat (20) tick();
    check("basic_len", selLog.size(), 8);
    for (int k = 0; k < 8; k++) if (k < selLog.size()) check("basic_sel", selLog[k], expA[k]);
    check("basic_firstValid", firstValid - pick, 5);
    check("basic_symDone", lastDone - pick, 12);
    check("basic_validCnt", validCnt, 8);
    check("basic_hIdx", bus.hIdx, 0);

    // h alternation and hReset.
    clearLogs();
    newSample(); dBase = 5'd0; dS0 = 5'd4; dS1 = 5'd6; dSym = 1; dHr = 1; tick();
    repeat (19) tick();
    newSample(); dBase = 5'd0; dS0 = 5'd4; dS1 = 5'd6; dSym = 1; tick();
    repeat (10) tick();
    check("h1_hIdx", bus.hIdx, 1);
    dHr = 1; tick();
    repeat (8) tick();
    newSample(); dBase = 5'd0; dS0 = 5'd4; dS1 = 5'd6; dSym = 1; tick();
    repeat (10) tick();
    check("h_len", selLog.size(), 24);
    if (selLog.size() >= 24) begin
      check("h0_sel1", selLog[1], 4);
      check("h1_sel1", selLog[9], 6);
      check("h1_sel7", selLog[15], 10);
      check("h0b_sel1", selLog[17], 4);
    end
    check("h0b_hIdx", bus.hIdx, 0);

    // Wrap: base 30, step 31.
    clearLogs();
    newSample(); dBase = 5'd30; dS0 = 5'd31; dS1 = 5'd31; dSym = 1; tick();
    repeat (12) tick();
    for (int k = 0; k < 8; k++) if (k < selLog.size()) check("wrap_sel", selLog[k], 30 - k);

    // Overrun: second symbol three cycles after the first.
    clearLogs();
    expB = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7};
    newSample(); dBase = 5'd7; dS0 = 5'd3; dS1 = 5'd11; dSym = 1; tick();
    tick(); tick();
    newSample(); dSym = 1; tick();
    repeat (20) tick();
    check("ovr_branches", brLog.size(), 11);
    for (int k = 0; k < 11; k++) if (k < brLog.size()) check("ovr_branch", brLog[k], expB[k]);
    check("ovr_doneCnt", doneCnt, 1);
    check("ovr_flag", bus.overrun, 1);
`ifdef ROT_SCHED_OVFCNT_EN
    check("ovr_count", bus.overrunCount, 1);
`endif
    dClr = 1; tick(); tick();
    check("ovr_cleared", bus.overrun, 0);

    // Back-to-back at exactly NB spacing: no overrun, 16 contiguous results.
    clearLogs();
    newSample(); dBase = 5'd1; dS0 = 5'd2; dS1 = 5'd3; dSym = 1; tick();
    repeat (NB - 1) tick();
    newSample(); dSym = 1; tick();
    repeat (20) tick();
    check("b2b_validCnt", validCnt, 16);
    check("b2b_contig", lastValid - firstValid, 15);
    check("b2b_doneCnt", doneCnt, 2);
    check("b2b_overrun", bus.overrun, 0);

    // Reset mid-sequence: symEn at T, reset at T+4.
    newSample(); dBase = 5'd9; dSym = 1; tick();
    repeat (3) tick();
    assertReset();
    repeat (3) tick();
    clearLogs();
    dRel = 1; tick();
    repeat (12) tick();
    check("rst_noValid", validCnt, 0);

    // Randomized traffic with one mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        assertReset();
        repeat (2) tick();
        dRel = 1;
      end
      newSample();
      dBase = 5'($urandom); dS0 = 5'($urandom); dS1 = 5'($urandom);
      pick = int'($urandom_range(0, 19));
      dSym = (pick < 3);
      dHr = ($urandom_range(0, 19) == 0);
      dClr = ($urandom_range(0, 24) == 0);
      tick();
    end
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
